// File: rtl/matrix_pkg.sv
// matrix_pkg: shared 8x8 LED matrix geometry, pixel/row types and clear-FSM states
package matrix_pkg;
  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  typedef logic [2:0] pixel_t;
  typedef struct packed {
    logic [MATRIX_COLS-1:0] red;
    logic [MATRIX_COLS-1:0] green;
    logic [MATRIX_COLS-1:0] blue;
  } row_t;
  typedef enum logic {IDLE, CLEAR} fb_state_t;
endpackage

// File: rtl/matrix_framebuffer_if.sv
// matrix_framebuffer_if: pixel-write, clear, swap and row-fetch signals of the frame store
// master = writer/driver side, slave = frame store side
interface matrix_framebuffer_if;
  import matrix_pkg::*;
  logic       wr_en;
  logic [5:0] wr_addr;
  pixel_t     wr_data;
  logic       wr_ready;
  logic       clear_req;
  logic       busy;
  logic       swap_req;
  logic       swap_pending;
  logic       swap_done;
  logic       row_req;
  logic [2:0] row_idx;
  logic       row_valid;
  logic [7:0] row_red;
  logic [7:0] row_green;
  logic [7:0] row_blue;
  modport master (
    output wr_en, wr_addr, wr_data, clear_req, swap_req, row_req, row_idx,
    input  wr_ready, busy, swap_pending, swap_done, row_valid, row_red, row_green, row_blue
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, clear_req, swap_req, row_req, row_idx,
    output wr_ready, busy, swap_pending, swap_done, row_valid, row_red, row_green, row_blue
  );
endinterface

// File: rtl/matrix_fb_bank.sv
// matrix_fb_bank: one 8x24 flop bank with pixel write, row clear and async row read
// ports: clk, rst, wr_en/wr_row/wr_col/wr_data, clr_en/clr_row, rd_row -> rd_data
module matrix_fb_bank
  import matrix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [2:0] wr_col,
  input  pixel_t     wr_data,
  input  logic       clr_en,
  input  logic [2:0] clr_row,
  input  logic [2:0] rd_row,
  output row_t       rd_data
);
  row_t mem [MATRIX_ROWS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MATRIX_ROWS; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_row] <= '0;
    end else if (wr_en) begin
      mem[wr_row].red[wr_col]   <= wr_data[2];
      mem[wr_row].green[wr_col] <= wr_data[1];
      mem[wr_row].blue[wr_col]  <= wr_data[0];
    end
  end
  assign rd_data = mem[rd_row];
endmodule

// File: rtl/matrix_framebuffer.sv
// matrix_framebuffer: double-buffered 8x8 RGB frame store feeding the LED matrix driver
// ports: clk_25mhz, rst (sync, active high), bus (matrix_framebuffer_if.slave)
// MATRIX_FB_DOUBLE_BUFFER_EN selects two banks with frame-boundary swaps; otherwise one bank
module matrix_framebuffer
  import matrix_pkg::*;
(
  input logic                  clk_25mhz,
  input logic                  rst,
  matrix_framebuffer_if.slave  bus
);
  fb_state_t  state;
  logic [2:0] clr_row;
  logic       busy;
  logic       wr_ok;
  logic       swap_done_d;
  row_t       rd_sel;
  row_t       row_q;
  logic       row_valid_q;
  logic       swap_done_q;
  assign busy  = state == CLEAR;
  assign wr_ok = bus.wr_en && !busy;
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      state   <= IDLE;
      clr_row <= '0;
    end else begin
      state   <= busy ? (clr_row == 3'd7 ? IDLE : CLEAR) : (bus.clear_req ? CLEAR : IDLE);
      clr_row <= busy ? clr_row + 3'd1 : '0;
    end
  end
`ifdef MATRIX_FB_DOUBLE_BUFFER_EN
  logic front_sel;
  logic swap_pending;
  logic do_swap;
  logic nxt_front;
  row_t rd [2];
  assign do_swap   = bus.row_req && bus.row_idx == 3'd0 && swap_pending && !busy;
  // reads in the swap cycle already see the new front; writes/clears use the pre-toggle back bank
  assign nxt_front = front_sel ^ do_swap;
  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_fb_bank u_bank (
      .clk     (clk_25mhz),
      .rst     (rst),
      .wr_en   (wr_ok && (front_sel ^ 1'(b))),
      .wr_row  (bus.wr_addr[5:3]),
      .wr_col  (bus.wr_addr[2:0]),
      .wr_data (bus.wr_data),
      .clr_en  (busy && (front_sel ^ 1'(b))),
      .clr_row (clr_row),
      .rd_row  (bus.row_idx),
      .rd_data (rd[b])
    );
  end
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      front_sel    <= nxt_front;
      swap_pending <= bus.swap_req || (swap_pending && !do_swap);
    end
  end
  assign swap_done_d      = do_swap;
  assign rd_sel           = rd[nxt_front];
  assign bus.swap_pending = swap_pending;
`else
  matrix_fb_bank u_bank (
    .clk     (clk_25mhz),
    .rst     (rst),
    .wr_en   (wr_ok),
    .wr_row  (bus.wr_addr[5:3]),
    .wr_col  (bus.wr_addr[2:0]),
    .wr_data (bus.wr_data),
    .clr_en  (busy),
    .clr_row (clr_row),
    .rd_row  (bus.row_idx),
    .rd_data (rd_sel)
  );
  assign swap_done_d      = bus.swap_req;
  assign bus.swap_pending = 1'b0;
`endif
  always_ff @(posedge clk_25mhz) begin
    if (rst) begin
      row_q       <= '0;
      row_valid_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      row_q       <= bus.row_req ? rd_sel : row_q;
      row_valid_q <= bus.row_req;
      swap_done_q <= swap_done_d;
    end
  end
  assign bus.wr_ready  = !busy;
  assign bus.busy      = busy;
  assign bus.swap_done = swap_done_q;
  assign bus.row_valid = row_valid_q;
  assign bus.row_red   = row_q.red;
  assign bus.row_green = row_q.green;
  assign bus.row_blue  = row_q.blue;
endmodule

// File: tb/tb_matrix_framebuffer.sv
// tb_matrix_framebuffer: directed self-checking bench for matrix_framebuffer (both buffer modes)
module tb_matrix_framebuffer;
  import matrix_pkg::*;
  logic clk_25mhz = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   failed = 0;
  int   total = 0;
  logic [23:0] d;
  logic        sd;
  matrix_framebuffer_if bus ();
  matrix_framebuffer dut (.clk_25mhz(clk_25mhz), .rst(rst), .bus(bus));
  always #20 clk_25mhz = ~clk_25mhz;
  task automatic tick;
    @(posedge clk_25mhz);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [5:0] a, input pixel_t p);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = p;
    tick();
    bus.wr_en = 1'b0;
  endtask
  task automatic rd(input logic [2:0] r, output logic [23:0] data, output logic done);
    bus.row_req = 1'b1;
    bus.row_idx = r;
    tick();
    bus.row_req = 1'b0;
    chk("row_valid", bus.row_valid, 1);
    data = {bus.row_red, bus.row_green, bus.row_blue};
    done = bus.swap_done;
  endtask
  task automatic rd_chk(input string tag, input logic [2:0] r, input logic [23:0] exp);
    logic [23:0] v;
    logic        s;
    rd(r, v, s);
    chk(tag, v, exp);
  endtask
  task automatic clear_drop(input logic [5:0] a);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    chk("busy_first", bus.busy, 1);
    chk("wr_ready_busy", bus.wr_ready, 0);
    for (int i = 2; i <= 8; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = 3'b111;
      bus.clear_req = (i == 4);
      tick();
      chk("busy_sweep", bus.busy, 1);
    end
    bus.wr_en = 1'b0;
    bus.clear_req = 1'b0;
    tick();
    chk("busy_end", bus.busy, 0);
    chk("wr_ready_end", bus.wr_ready, 1);
  endtask
  task automatic reset_checks;
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    chk("rst_swap_pending", bus.swap_pending, 0);
    chk("rst_swap_done", bus.swap_done, 0);
    chk("rst_row_valid", bus.row_valid, 0);
    chk("rst_rows", {bus.row_red, bus.row_green, bus.row_blue}, 0);
  endtask
  initial begin
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.clear_req = 1'b0;
    bus.swap_req = 1'b0;
    bus.row_req = 1'b0;
    bus.row_idx = '0;
    tick();
    tick();
    reset_checks();
    rst = 1'b0;
    for (int r = 0; r < 8; r++) rd_chk("reset_row", 3'(r), 24'h0);
    tick();
    chk("row_valid_pulse", bus.row_valid, 0);
`ifdef MATRIX_FB_DOUBLE_BUFFER_EN
    wr(6'o23, 3'b100);
    rd(3'd2, d, sd);
    chk("back_hidden", d, 24'h0);
    chk("no_swap_row2", sd, 0);
    bus.swap_req = 1'b1;
    tick();
    chk("pending_set", bus.swap_pending, 1);
    chk("swap_done_early", bus.swap_done, 0);
    tick();
    bus.swap_req = 1'b0;
    chk("pending_idem", bus.swap_pending, 1);
    rd(3'd0, d, sd);
    chk("swap_done_boundary", sd, 1);
    chk("pending_cleared", bus.swap_pending, 0);
    rd(3'd2, d, sd);
    chk("swapped_row2", d, 24'h080000);
    chk("swap_done_pulse", sd, 0);
    for (int i = 0; i < 64; i++) wr(6'(i), 3'b111);
    rd_chk("front_kept", 3'd2, 24'h080000);
    clear_drop(6'o51);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    rd(3'd0, d, sd);
    chk("swap_after_clear", sd, 1);
    for (int r = 0; r < 8; r++) rd_chk("cleared_row", 3'(r), 24'h0);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    rd(3'd0, d, sd);
    chk("no_swap_busy", sd, 0);
    chk("pending_busy", bus.swap_pending, 1);
    for (int i = 0; i < 6; i++) tick();
    chk("busy_done", bus.busy, 0);
    wr(6'o77, 3'b001);
    rd(3'd0, d, sd);
    chk("deferred_swap", sd, 1);
    rd_chk("deferred_row7", 3'd7, 24'h000080);
    rd_chk("deferred_row2", 3'd2, 24'h0);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_addr = 6'o10;
    bus.wr_data = 3'b100;
    bus.row_req = 1'b1;
    bus.row_idx = 3'd0;
    tick();
    bus.wr_en = 1'b0;
    bus.row_req = 1'b0;
    chk("swap_with_write", bus.swap_done, 1);
    rd_chk("write_in_swap", 3'd1, 24'h010000);
    rd_chk("new_front_row7", 3'd7, 24'h0);
    rd_chk("pre_reset_row1", 3'd1, 24'h010000);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    reset_checks();
    rst = 1'b0;
    rd(3'd0, d, sd);
    chk("post_reset_no_swap", sd, 0);
    chk("post_reset_row0", d, 24'h0);
    rd_chk("post_reset_row1", 3'd1, 24'h0);
`else
    wr(6'o77, 3'b001);
    rd_chk("px77", 3'd7, 24'h000080);
    wr(6'o23, 3'b100);
    rd_chk("px23_red", 3'd2, 24'h080000);
    wr(6'o23, 3'b011);
    rd_chk("px23_overwrite", 3'd2, 24'h000808);
    wr(6'o20, 3'b111);
    rd_chk("px20_merge", 3'd2, 24'h010909);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("swap_done_single", bus.swap_done, 1);
    chk("pending_tied", bus.swap_pending, 0);
    tick();
    chk("swap_done_pulse", bus.swap_done, 0);
    wr(6'o50, 3'b111);
    rd_chk("px50", 3'd5, 24'h010101);
    clear_drop(6'o51);
    rd_chk("cleared_row5", 3'd5, 24'h0);
    rd_chk("cleared_row2", 3'd2, 24'h0);
    rd_chk("cleared_row7", 3'd7, 24'h0);
    wr(6'o51, 3'b111);
    rd_chk("write_after_clear", 3'd5, 24'h020202);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    tick();
    bus.swap_req = 1'b1;
    rst = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    reset_checks();
    rst = 1'b0;
    rd_chk("post_reset_row5", 3'd5, 24'h0);
    tick();
    chk("post_reset_busy", bus.busy, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
